vx_tcu_drl_align: RTL

Downstream neighbour of the TCU DRL multiply/exponent stage. Consumes per-lane raw significands, per-lane shift amounts, the shared max exponent, exception flags and the lane mask. Right-aligns every significand to the max exponent in an accumulator-width datapath and produces a per-lane sticky bit. It is a 2-deep elastic pipeline with valid/ready handshakes that feeds the accumulator/adder-tree stage.

---
 rtl/vx_tcu_drl_align_pkg.sv | 32 +++
 rtl/vx_tcu_drl_align_if.sv | 50 +++++
 rtl/vx_tcu_drl_align_lane.sv | 49 ++++
 rtl/vx_tcu_drl_align.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_align_pkg.sv
// ---------------------------------------------------------------------------
// VX_tcu_pkg
//   Shared TCU types and default geometry for the DRL alignment stage.
//   - fedp_excep_t    : exception flags that ride along with each request
//   - tcu_align_req_t : one alignment request at the default geometry
//                       (TCU_TCK product lanes + 1 C-operand lane)
// ---------------------------------------------------------------------------
package VX_tcu_pkg;

    localparam int TCU_N     = 2;
    localparam int TCU_TCK   = 2 * TCU_N;
    localparam int TCU_W     = 25;
    localparam int TCU_WA    = 28;
    localparam int TCU_EXP_W = 10;

    typedef struct packed {
        logic is_nan;
        logic is_pinf;
        logic is_ninf;
        logic is_invalid;
    } fedp_excep_t;

    typedef struct packed {
        logic [31:0]                    req_id;
        logic [TCU_EXP_W-1:0]           max_exp;
        logic [(TCU_TCK+1)*8-1:0]       shift_amt;
        logic [(TCU_TCK+1)*TCU_W-1:0]   raw_sigs;
        fedp_excep_t                    exceptions;
        logic [TCU_TCK-1:0]             lane_mask;
    } tcu_align_req_t;

endpackage

// File: rtl/vx_tcu_drl_align_if.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_align_if
//   Request/response bundle of the DRL alignment stage.
//   slave  : the alignment block (consumes *_in, produces outputs)
//   master : the surrounding logic (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface vx_tcu_drl_align_if
    import VX_tcu_pkg::*;
#(
    parameter int TCK   = TCU_TCK,
    parameter int W     = TCU_W,
    parameter int WA    = TCU_WA,
    parameter int EXP_W = TCU_EXP_W
) ();

    // upstream side
    logic                   valid_in;
    logic                   ready_in;
    logic [31:0]            req_id_in;
    logic [EXP_W-1:0]       max_exp_in;
    logic [(TCK+1)*8-1:0]   shift_amt_in;
    logic [(TCK+1)*W-1:0]   raw_sigs_in;
    fedp_excep_t            exceptions_in;
    logic [TCK-1:0]         lane_mask_in;

    // downstream side
    logic                   valid_out;
    logic                   ready_out;
    logic [31:0]            req_id_out;
    logic [EXP_W-1:0]       max_exp_out;
    logic [(TCK+1)*WA-1:0]  aligned_sigs;
    logic [TCK:0]           sticky;
    fedp_excep_t            exceptions_out;
    logic [TCK-1:0]         lane_mask_out;

    modport slave (
        input  valid_in, req_id_in, max_exp_in, shift_amt_in, raw_sigs_in,
               exceptions_in, lane_mask_in, ready_out,
        output ready_in, valid_out, req_id_out, max_exp_out, aligned_sigs,
               sticky, exceptions_out, lane_mask_out
    );

    modport master (
        output valid_in, req_id_in, max_exp_in, shift_amt_in, raw_sigs_in,
               exceptions_in, lane_mask_in, ready_out,
        input  ready_in, valid_out, req_id_out, max_exp_out, aligned_sigs,
               sticky, exceptions_out, lane_mask_out
    );

endinterface

// File: rtl/vx_tcu_drl_align_lane.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_align_lane
//   Combinational single-lane alignment: pads the signed significand with
//   WA-W fraction bits, arithmetic-right-shifts it and reports the sticky OR
//   of everything shifted out. Inactive lanes produce zero / no sticky.
//   i_sig      : W-bit two's-complement significand
//   i_shift    : right-shift amount
//   i_active   : lane enabled
//   o_aligned  : WA-bit aligned significand
//   o_sticky   : OR of discarded bits
// ---------------------------------------------------------------------------
module vx_tcu_drl_align_lane
    import VX_tcu_pkg::*;
#(
    parameter int W  = TCU_W,
    parameter int WA = TCU_WA
) (
    input  logic [W-1:0]    i_sig,
    input  logic [7:0]      i_shift,
    input  logic            i_active,
    output logic [WA-1:0]   o_aligned,
    output logic            o_sticky
);

    // Sign extension followed by the left pad collapses to appending zeros:
    // the extension bits are exactly the ones pushed out the top.
    logic signed [WA-1:0] w_ext;
    logic [WA-1:0]        w_lost_mask;
    logic                 w_in_range;

    assign w_ext       = {i_sig, {(WA-W){1'b0}}};
    assign w_in_range  = (i_shift < 8'(WA));
    // Low i_shift bits set; only consulted while the shift is in range.
    assign w_lost_mask = (WA'(1) << i_shift) - WA'(1);

    always_comb begin
        o_aligned = '0;
        o_sticky  = 1'b0;
        if (i_active) begin
            if (w_in_range) begin
                o_aligned = w_ext >>> i_shift;
                o_sticky  = |(w_ext & w_lost_mask);
            end else begin
                o_sticky  = |i_sig;
            end
        end
    end

endmodule

// File: rtl/vx_tcu_drl_align.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_align
//   2-deep elastic pipeline that right-aligns TCK+1 signed significands to
//   the shared max exponent and produces per-lane sticky bits.
//   S1 registers the request; S2 holds the aligned result and drives outputs.
//   clk / reset : clock, asynchronous active-high reset
//   bus (slave) : valid/ready request in, valid/ready aligned result out,
//                 req_id / max_exp / exceptions / lane_mask passed through
// ---------------------------------------------------------------------------
module vx_tcu_drl_align
    import VX_tcu_pkg::*;
#(
    parameter int N     = TCU_N,
    parameter int TCK   = 2 * N,
    parameter int W     = TCU_W,
    parameter int WA    = TCU_WA,
    parameter int EXP_W = TCU_EXP_W
) (
    input  logic                clk,
    input  logic                reset,
    vx_tcu_drl_align_if.slave   bus
);

    // ---------------- handshake control ----------------
    logic r_s1_valid, r_s2_valid;
    logic w_s1_load, w_s2_load;

    assign w_s2_load   = !r_s2_valid || bus.ready_out;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign bus.ready_in = w_s1_load;

    // ---------------- stage 1: captured request ----------------
    logic [31:0]            r_s1_req_id;
    logic [EXP_W-1:0]       r_s1_max_exp;
    logic [(TCK+1)*8-1:0]   r_s1_shift;
    logic [(TCK+1)*W-1:0]   r_s1_sigs;
    fedp_excep_t            r_s1_excep;
    logic [TCK-1:0]         r_s1_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_req_id  <= '0;
            r_s1_max_exp <= '0;
            r_s1_shift   <= '0;
            r_s1_sigs    <= '0;
            r_s1_excep   <= '0;
            r_s1_mask    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r_s1_req_id  <= bus.req_id_in;
                r_s1_max_exp <= bus.max_exp_in;
                r_s1_shift   <= bus.shift_amt_in;
                r_s1_sigs    <= bus.raw_sigs_in;
                r_s1_excep   <= bus.exceptions_in;
                r_s1_mask    <= bus.lane_mask_in;
            end
        end
    end

    // ---------------- per-lane alignment ----------------
    logic [TCK:0][WA-1:0] w_aligned;
    logic [TCK:0]         w_sticky;

    for (genvar g = 0; g <= TCK; g++) begin : g_lane
        logic w_active;
        if (g < TCK) begin : g_prod
            assign w_active = r_s1_mask[g];
        end else begin : g_c
            assign w_active = 1'b1;     // C-operand lane is never masked
        end

        vx_tcu_drl_align_lane #(
            .W  (W),
            .WA (WA)
        ) u_lane (
            .i_sig     (r_s1_sigs[g*W +: W]),
            .i_shift   (r_s1_shift[g*8 +: 8]),
            .i_active  (w_active),
            .o_aligned (w_aligned[g]),
            .o_sticky  (w_sticky[g])
        );
    end

    // ---------------- stage 2: result / outputs ----------------
    logic [31:0]            r_s2_req_id;
    logic [EXP_W-1:0]       r_s2_max_exp;
    logic [(TCK+1)*WA-1:0]  r_s2_aligned;
    logic [TCK:0]           r_s2_sticky;
    fedp_excep_t            r_s2_excep;
    logic [TCK-1:0]         r_s2_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_req_id  <= '0;
            r_s2_max_exp <= '0;
            r_s2_aligned <= '0;
            r_s2_sticky  <= '0;
            r_s2_excep   <= '0;
            r_s2_mask    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            // Data only moves with a real request so a drained S2 keeps its
            // last contents instead of toggling on bubbles.
            if (r_s1_valid) begin
                r_s2_req_id  <= r_s1_req_id;
                r_s2_max_exp <= r_s1_max_exp;
                r_s2_aligned <= w_aligned;
                r_s2_sticky  <= w_sticky;
                r_s2_excep   <= r_s1_excep;
                r_s2_mask    <= r_s1_mask;
            end
        end
    end

    assign bus.valid_out      = r_s2_valid;
    assign bus.req_id_out     = r_s2_req_id;
    assign bus.max_exp_out    = r_s2_max_exp;
    assign bus.aligned_sigs   = r_s2_aligned;
    assign bus.sticky         = r_s2_sticky;
    assign bus.exceptions_out = r_s2_excep;
    assign bus.lane_mask_out  = r_s2_mask;

endmodule
